wb_burst_master: RTL and testbench
==================================

// Module: wb_burst_master
// PURPOSE
// - Wishbone classic/registered-burst initiator that drives the SDRAM controller's wb slave port.
// - Converts single-command requests (addr, dir, length) into Wishbone single or incrementing-burst cycles.
// - Buffers write data before the bus cycle; streams read data out per ack; reports completion/error.
// - Serves as the bus-side stimulus engine for SDRAM system tests and for on-chip DMA-style clients.
// PARAMETERS
// - AW             32   Wishbone byte-address width
// - DW             32   data width (multiple of 8); SW = DW/8 select bits
// - MAX_BURST      8    max beats per command (power of 2, >=2); LW = $clog2(MAX_BURST)
// - TIMEOUT_CYCLES 256  cycles without ack before abort (only with WB_MASTER_TIMEOUT_EN)
// PORTS
// - wb_clk_i    in   1     the single clock
// - wb_rst_i    in   1     synchronous, active-high reset
// - cmd_valid   in   1     command request
// - cmd_ready   out  1     command accepted when cmd_valid&cmd_ready
// - cmd_we      in   1     1=write, 0=read
// - cmd_addr    in   AW    start byte address (DW-aligned)
// - cmd_sel     in   SW    byte select used on every beat
// - cmd_len     in   LW    beats-1 (0 = single transfer)
// - wdat_valid  in   1     write-data word offered
// - wdat_ready  out  1     write-data word accepted
// - wdat        in   DW    write-data word
// - rdat_valid  out  1     one-cycle pulse per read beat; no backpressure
// - rdat        out  DW    read-data word
// - done        out  1     one-cycle pulse at command end
// - done_err    out  1     valid with done: 1 = timeout abort
// - done_beats  out  LW+1  beats acked for the command
// - wb_cyc_o, wb_stb_o  out 1  bus cycle / strobe (always identical)
// - wb_we_o     out  1     write enable
// - wb_addr_o   out  AW    address
// - wb_dat_o    out  DW    write data
// - wb_sel_o    out  SW    byte select
// - wb_cti_o    out  3     cycle type identifier
// - wb_ack_i    in   1     slave acknowledge
// - wb_dat_i    in   DW    slave read data
// BEHAVIOUR
// - Reset: all outputs 0 (cyc, stb, we, addr, dat, sel, cti, cmd_ready, wdat_ready, rdat_valid, done*), state IDLE; write buffer contents don't-care.
// - Reset mid-operation: cyc/stb drop the cycle after wb_rst_i is sampled high; command discarded, no done pulse.
// - States: IDLE, LOAD, BUS, DONE.
// - IDLE: cmd_ready=1. On accept, latch cmd_*; write -> LOAD, read -> BUS (cyc/stb high the next cycle).
// - LOAD: wdat_ready=1; store cmd_len+1 words in order into buffer (depth MAX_BURST); after the last word -> BUS.
// - BUS: cyc=stb=1, all wb_*_o registered. Beat n: addr = start + n*SW (wraps modulo 2^AW), dat = buf[n].
// - cti: 3'b000 if cmd_len==0; otherwise 3'b010 on every beat except the last, 3'b111 on the last.
// - ack counts only when sampled with stb=1. On ack, the next beat is presented in the following cycle.
// - Read: rdat_valid pulses with rdat=wb_dat_i in the cycle after each ack.
// - Last ack: cyc/stb/we/sel/cti return to 0 the next cycle -> DONE.
// - DONE: done=1 for one cycle, then IDLE. Minimum 1 idle cycle between bus cycles.
// - done_beats = number of acks received; done_err=0 on normal completion.
// - Ack outside BUS is ignored. cmd_valid outside IDLE is not accepted.
// CONFIGURATION
// - WB_MASTER_TIMEOUT_EN defined: counter cleared on entry to BUS and on each ack.
//   - Reaching TIMEOUT_CYCLES with no ack drops cyc/stb next cycle -> DONE with done_err=1; done_beats = acks so far.
// - WB_MASTER_TIMEOUT_EN undefined: waits indefinitely; done_err is tied to 0.
// TESTING
// - Reset: hold wb_rst_i 3 cycles mid-burst -> cyc/stb/addr/dat/sel/cti all 0 from the cycle after assertion; no done.
// - Single read: addr=0x100, len=0, ack 2 cycles after stb -> cti=000; rdat_valid once; done_beats=1, done_err=0.
// - Write burst: addr=0x40, len=3, words A0..A3 -> addr 0x40,44,48,4C; cti 010,010,010,111; dat A0..A3 in order; done_beats=4.
// - Wrap: addr=0xFFFFFFF8, len=3 read -> addrs FFFFFFF8, FFFFFFFC, 00000000, 00000004.
// - Timeout (EN, TIMEOUT_CYCLES=16): no ack -> cyc drops after 16 stall cycles; done_err=1, done_beats=0.
// - Protocol check throughout: wb_stb_o==wb_cyc_o every cycle; stray ack while idle has no effect.

Source files
------------

// File: rtl/wb_burst_master.sv
// wb_burst_master
// Wishbone classic / incrementing-burst initiator. A command (address, direction,
// beat count) becomes one bus cycle of cmd_len+1 beats. Write data is buffered in
// full before the cycle starts; read data streams out one word per ack.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-high reset
//   cmd_valid/cmd_ready         command handshake (accepted only in IDLE)
//   cmd_we, cmd_addr, cmd_sel   direction, start byte address, byte select
//   cmd_len                     beats-1 (0 = single transfer)
//   wdat_valid/wdat_ready/wdat  write-data stream, cmd_len+1 words per write
//   rdat_valid, rdat            one-cycle pulse per read beat, no backpressure
//   done, done_err, done_beats  completion pulse, timeout flag, acked beats
//   wb_*_o / wb_ack_i, wb_dat_i Wishbone initiator port (all outputs registered)
//
// Configuration
//   WB_MASTER_TIMEOUT_EN  when defined, a cycle that sees no ack for
//                         TIMEOUT_CYCLES cycles is aborted with done_err=1.
//                         When undefined the master waits forever and
//                         done_err is tied to 0.

module wb_burst_master #(
  parameter  int AW             = 32,
  parameter  int DW             = 32,
  parameter  int MAX_BURST      = 8,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int SW             = DW / 8,
  localparam int LW             = $clog2(MAX_BURST)
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [SW-1:0] cmd_sel,
  input  logic [LW-1:0] cmd_len,
  input  logic          wdat_valid,
  output logic          wdat_ready,
  input  logic [DW-1:0] wdat,
  output logic          rdat_valid,
  output logic [DW-1:0] rdat,
  output logic          done,
  output logic          done_err,
  output logic [LW:0]   done_beats,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_addr_o,
  output logic [DW-1:0] wb_dat_o,
  output logic [SW-1:0] wb_sel_o,
  output logic [2:0]    wb_cti_o,
  input  logic          wb_ack_i,
  input  logic [DW-1:0] wb_dat_i
);

  typedef enum logic [1:0] {IDLE, LOAD, BUS, DONE} state_t;

  localparam logic [AW-1:0] ADDR_STEP = AW'(SW);
  localparam logic [LW-1:0] IDX_ONE   = LW'(1);
  localparam logic [LW:0]   ACK_ONE   = (LW+1)'(1);
  localparam logic [2:0]    CTI_CLASSIC = 3'b000;
  localparam logic [2:0]    CTI_INCR    = 3'b010;
  localparam logic [2:0]    CTI_END     = 3'b111;

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d, idx_next;
  logic [AW-1:0] start_q, start_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [LW:0]   acks_q, acks_d;
  logic          cyc_d, we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] dat_d;
  logic [SW-1:0] wsel_d;
  logic [2:0]    cti_d;
  logic          rdv_d;
  logic          buf_wr;
  logic          ack_ok;
  logic [DW-1:0] wbuf [MAX_BURST];

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tocnt_q, tocnt_d;
  logic          err_q, err_d;
`endif

  // Handshake strobes come straight from the state so a command or word is
  // accepted in the same cycle it is offered; reset masks them immediately.
  assign cmd_ready  = (state_q == IDLE) && !wb_rst_i;
  assign wdat_ready = (state_q == LOAD) && !wb_rst_i;
  assign done       = (state_q == DONE) && !wb_rst_i;
  assign done_beats = acks_q;
  assign wb_stb_o   = wb_cyc_o;
  assign ack_ok     = wb_ack_i && wb_stb_o && (state_q == BUS);
  assign idx_next   = idx_q + IDX_ONE;

`ifdef WB_MASTER_TIMEOUT_EN
  assign done_err = err_q;
`else
  logic unused_timeout;
  assign done_err       = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Next-state and next-bus-value logic. Bus outputs are computed one cycle
  // ahead so that every wb_*_o leaves a flop; idx counts loaded words in LOAD
  // and the current beat in BUS.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    start_d = start_q;
    sel_d   = sel_q;
    acks_d  = acks_q;
    cyc_d   = wb_cyc_o;
    we_d    = wb_we_o;
    addr_d  = wb_addr_o;
    dat_d   = wb_dat_o;
    wsel_d  = wb_sel_o;
    cti_d   = wb_cti_o;
    rdv_d   = 1'b0;
    buf_wr  = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    tocnt_d = '0;
    err_d   = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          len_d   = cmd_len;
          start_d = cmd_addr;
          sel_d   = cmd_sel;
          idx_d   = '0;
          acks_d  = '0;
`ifdef WB_MASTER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          if (cmd_we) begin
            state_d = LOAD;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b0;
            addr_d  = cmd_addr;
            dat_d   = '0;
            wsel_d  = cmd_sel;
            cti_d   = (cmd_len == '0) ? CTI_CLASSIC : CTI_INCR;
          end
        end
      end

      LOAD: begin
        if (wdat_valid) begin
          buf_wr = 1'b1;
          if (idx_q == len_q) begin
            // The last word is still in flight to the buffer this cycle,
            // so a single-beat write takes its data from the input port.
            state_d = BUS;
            idx_d   = '0;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            addr_d  = start_q;
            dat_d   = (len_q == '0) ? wdat : wbuf[0];
            wsel_d  = sel_q;
            cti_d   = (len_q == '0) ? CTI_CLASSIC : CTI_INCR;
          end else begin
            idx_d = idx_next;
          end
        end
      end

      BUS: begin
        if (ack_ok) begin
          acks_d = acks_q + ACK_ONE;
          rdv_d  = !wb_we_o;
          if (idx_q == len_q) begin
            state_d = DONE;
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = '0;
            dat_d   = '0;
            wsel_d  = '0;
            cti_d   = CTI_CLASSIC;
          end else begin
            idx_d  = idx_next;
            addr_d = wb_addr_o + ADDR_STEP;
            dat_d  = wb_we_o ? wbuf[idx_next] : '0;
            cti_d  = (idx_next == len_q) ? CTI_END : CTI_INCR;
          end
`ifdef WB_MASTER_TIMEOUT_EN
        end else if (tocnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          dat_d   = '0;
          wsel_d  = '0;
          cti_d   = CTI_CLASSIC;
        end else begin
          tocnt_d = tocnt_q + TW'(1);
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, command and bus registers; reset clears every visible output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      start_q    <= '0;
      sel_q      <= '0;
      acks_q     <= '0;
      wb_cyc_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      wb_cti_o   <= 3'b000;
      rdat_valid <= 1'b0;
      rdat       <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      tocnt_q    <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      start_q    <= start_d;
      sel_q      <= sel_d;
      acks_q     <= acks_d;
      wb_cyc_o   <= cyc_d;
      wb_we_o    <= we_d;
      wb_addr_o  <= addr_d;
      wb_dat_o   <= dat_d;
      wb_sel_o   <= wsel_d;
      wb_cti_o   <= cti_d;
      rdat_valid <= rdv_d;
      if (rdv_d) begin
        rdat <= wb_dat_i;
      end
`ifdef WB_MASTER_TIMEOUT_EN
      tocnt_q    <= tocnt_d;
      err_q      <= err_d;
`endif
    end
  end

  // Write buffer: contents are meaningless after reset, so it has none.
  always_ff @(posedge wb_clk_i) begin
    if (buf_wr) begin
      wbuf[idx_q] <= wdat;
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master
// Self-checking bench for wb_burst_master. Each scenario task pushes the beats,
// read words and completion it expects into scoreboard queues before driving the
// command; a negedge process acting as Wishbone slave and output monitor pops
// and compares them as the design produces them.

module tb_wb_burst_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int LW = 3;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] dat;
    logic          we;
    logic [2:0]    cti;
    logic [SW-1:0] sel;
  } beat_t;

  typedef struct {
    logic        err;
    logic [LW:0] beats;
  } done_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_we = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [SW-1:0] cmd_sel = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          wdat_valid = 1'b0;
  logic          wdat_ready;
  logic [DW-1:0] wdat = '0;
  logic          rdat_valid;
  logic [DW-1:0] rdat;
  logic          done;
  logic          done_err;
  logic [LW:0]   done_beats;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel_o;
  logic [2:0]    wb_cti_o;
  logic          wb_ack_i = 1'b0;
  logic [DW-1:0] wb_dat_i = '0;

  beat_t         beat_q[$];
  logic [DW-1:0] rdat_q[$];
  done_t         done_q[$];
  beat_t         sl_e;
  done_t         dn_e;
  logic [DW-1:0] rd_e;

  int vectors     = 0;
  int miscompares = 0;
  int done_count  = 0;
  int ack_lat     = 0;
  int wait_cnt    = 0;
  bit slave_en    = 1'b0;
  bit stray_ack   = 1'b0;

  wb_burst_master #(
    .AW(AW), .DW(DW), .MAX_BURST(8), .TIMEOUT_CYCLES(16)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wdat_valid(wdat_valid), .wdat_ready(wdat_ready), .wdat(wdat),
    .rdat_valid(rdat_valid), .rdat(rdat),
    .done(done), .done_err(done_err), .done_beats(done_beats),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  always #5 clk = ~clk;

  // Slave memory contents: a fixed scramble of the address.
  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction

  // Slave and monitor: protocol check, read-data and completion scoreboard,
  // then the ack decision for the next rising edge with beat-content checks.
  always @(negedge clk) begin
    vectors++;
    if (wb_stb_o !== wb_cyc_o) begin
      miscompares++;
      $display("[TB] FAIL stb_eq_cyc: stb=%b cyc=%b", wb_stb_o, wb_cyc_o);
    end
    if (rdat_valid === 1'b1) begin
      vectors++;
      if (rdat_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL rdat_unexpected: got %h, expected no read word", rdat);
      end else begin
        rd_e = rdat_q.pop_front();
        if (rdat !== rd_e) begin
          miscompares++;
          $display("[TB] FAIL rdat: got %h expected %h", rdat, rd_e);
        end
      end
    end
    if (done === 1'b1) begin
      done_count++;
      vectors += 2;
      if (wb_cyc_o !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL cyc_at_done: got %b expected 0", wb_cyc_o);
      end
      if (done_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL done_unexpected: got done err=%b beats=%0d, expected none", done_err, done_beats);
      end else begin
        dn_e = done_q.pop_front();
        if ({done_err, done_beats} !== {dn_e.err, dn_e.beats}) begin
          miscompares++;
          $display("[TB] FAIL done_status: got err=%b beats=%0d expected err=%b beats=%0d",
                   done_err, done_beats, dn_e.err, dn_e.beats);
        end
      end
    end
    if (rst) begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (stray_ack) begin
      wb_ack_i = 1'b1;
    end else if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (slave_en && wb_cyc_o && wb_stb_o) begin
      if (wait_cnt >= ack_lat) begin
        wb_ack_i = 1'b1;
        wb_dat_i = rd_model(wb_addr_o);
        wait_cnt = 0;
        vectors++;
        if (beat_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL beat_unexpected: got addr %h, expected no beat", wb_addr_o);
        end else begin
          sl_e = beat_q.pop_front();
          if ({wb_addr_o, wb_we_o, wb_cti_o, wb_sel_o} !== {sl_e.addr, sl_e.we, sl_e.cti, sl_e.sel}) begin
            miscompares++;
            $display("[TB] FAIL beat_ctrl: got addr=%h we=%b cti=%b sel=%h expected addr=%h we=%b cti=%b sel=%h",
                     wb_addr_o, wb_we_o, wb_cti_o, wb_sel_o, sl_e.addr, sl_e.we, sl_e.cti, sl_e.sel);
          end
          if (sl_e.we) begin
            vectors++;
            if (wb_dat_o !== sl_e.dat) begin
              miscompares++;
              $display("[TB] FAIL beat_dat: got %h expected %h", wb_dat_o, sl_e.dat);
            end
          end
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Push the full expected outcome of one command into the scoreboard.
  task automatic expect_cmd(input logic we, input logic [AW-1:0] addr,
                            input logic [LW-1:0] len, input logic [DW-1:0] base);
    beat_t b;
    done_t d;
    for (int n = 0; n <= int'(len); n++) begin
      b.addr = addr + AW'(4 * n);
      b.dat  = we ? base + DW'(n) : '0;
      b.we   = we;
      b.cti  = (len == 0) ? 3'b000 : ((n == int'(len)) ? 3'b111 : 3'b010);
      b.sel  = 4'hF;
      beat_q.push_back(b);
      if (!we) rdat_q.push_back(rd_model(b.addr));
    end
    d.err   = 1'b0;
    d.beats = {1'b0, len} + 4'd1;
    done_q.push_back(d);
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    int b;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = addr;
    cmd_len   = len;
    cmd_sel   = 4'hF;
    b = 0;
    while (!cmd_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!cmd_ready) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL cmd_accept: got cmd_ready=0 for 200 cycles, expected 1");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input logic [DW-1:0] base);
    int b;
    for (int i = 0; i < n; i++) begin
      wdat       = base + DW'(i);
      wdat_valid = 1'b1;
      b = 0;
      while (!wdat_ready && b < 200) begin
        @(negedge clk);
        b++;
      end
      if (!wdat_ready) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL wdat_accept: got wdat_ready=0 for 200 cycles, expected 1");
      end
      @(negedge clk);
    end
    wdat_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int b;
    b = 0;
    while (done_count < target && b < limit) begin
      @(negedge clk);
      b++;
    end
    if (done_count < target) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL done_timeout: got %0d completions expected %0d", done_count, target);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    repeat (3) @(negedge clk);
    vectors++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
         cmd_ready, wdat_ready, rdat_valid, done, done_err, done_beats} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got cyc=%b addr=%h dat=%h sel=%h cti=%b ready=%b/%b done=%b expected all 0",
               wb_cyc_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o, cmd_ready, wdat_ready, done);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL idle_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single_read();
    int start;
    $display("[TB] test_single_read");
    start    = done_count;
    slave_en = 1'b1;
    ack_lat  = 1;
    expect_cmd(1'b0, 32'h100, 3'd0, '0);
    send_cmd(1'b0, 32'h100, 3'd0);
    wait_done(start + 1, 100);
    vectors++;
    if (beat_q.size() + rdat_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single_read_left: got %0d/%0d/%0d pending expected 0/0/0",
               beat_q.size(), rdat_q.size(), done_q.size());
    end
  endtask

  task automatic test_write_burst();
    int start;
    $display("[TB] test_write_burst");
    start   = done_count;
    ack_lat = 1;
    expect_cmd(1'b1, 32'h40, 3'd3, 32'hDEAD_00A0);
    send_cmd(1'b1, 32'h40, 3'd3);
    send_words(4, 32'hDEAD_00A0);
    wait_done(start + 1, 100);
    vectors++;
    if (beat_q.size() + rdat_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL write_burst_left: got %0d/%0d pending expected 0/0", beat_q.size(), done_q.size());
    end
  endtask

  task automatic test_wrap();
    int start;
    $display("[TB] test_wrap");
    start   = done_count;
    ack_lat = 0;
    expect_cmd(1'b0, 32'hFFFF_FFF8, 3'd3, '0);
    send_cmd(1'b0, 32'hFFFF_FFF8, 3'd3);
    wait_done(start + 1, 100);
    vectors++;
    if (beat_q.size() + rdat_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL wrap_left: got %0d/%0d/%0d pending expected 0/0/0",
               beat_q.size(), rdat_q.size(), done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int start;
    $display("[TB] test_back_to_back");
    start   = done_count;
    ack_lat = 0;
    expect_cmd(1'b1, 32'h1000, 3'd7, 32'h1234_5600);
    expect_cmd(1'b0, 32'h2000, 3'd7, '0);
    send_cmd(1'b1, 32'h1000, 3'd7);
    send_words(8, 32'h1234_5600);
    send_cmd(1'b0, 32'h2000, 3'd7);
    wait_done(start + 2, 200);
    vectors++;
    if (beat_q.size() + rdat_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_left: got %0d/%0d/%0d pending expected 0/0/0",
               beat_q.size(), rdat_q.size(), done_q.size());
    end
  endtask

  task automatic test_stray_ack();
    int start;
    $display("[TB] test_stray_ack");
    slave_en  = 1'b0;
    stray_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({wb_cyc_o, cmd_ready} !== 2'b01) begin
        miscompares++;
        $display("[TB] FAIL stray_ack_idle: got cyc=%b ready=%b expected cyc=0 ready=1", wb_cyc_o, cmd_ready);
      end
    end
    stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    start    = done_count;
    slave_en = 1'b1;
    ack_lat  = 2;
    expect_cmd(1'b0, 32'h300, 3'd1, '0);
    send_cmd(1'b0, 32'h300, 3'd1);
    wait_done(start + 1, 100);
    vectors++;
    if (beat_q.size() + rdat_q.size() + done_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL stray_after_left: got %0d/%0d/%0d pending expected 0/0/0",
               beat_q.size(), rdat_q.size(), done_q.size());
    end
  endtask

`ifdef WB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    int    start;
    int    b;
    int    hi;
    done_t d;
    $display("[TB] test_timeout");
    start    = done_count;
    slave_en = 1'b0;
    d.err    = 1'b1;
    d.beats  = '0;
    done_q.push_back(d);
    send_cmd(1'b0, 32'h200, 3'd1);
    b = 0;
    while (!wb_cyc_o && b < 20) begin
      @(negedge clk);
      b++;
    end
    hi = 0;
    while (wb_cyc_o && hi < 100) begin
      hi++;
      @(negedge clk);
    end
    vectors++;
    if (hi != 16) begin
      miscompares++;
      $display("[TB] FAIL timeout_len: got %0d stall cycles expected 16", hi);
    end
    wait_done(start + 1, 50);
    vectors++;
    if (done_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_left: got %0d pending completions expected 0", done_q.size());
    end
    slave_en = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_burst();
    int start;
    int b;
    $display("[TB] test_reset_mid_burst");
    start    = done_count;
    slave_en = 1'b1;
    ack_lat  = 3;
    expect_cmd(1'b1, 32'h80, 3'd3, 32'hCAFE_0000);
    send_cmd(1'b1, 32'h80, 3'd3);
    send_words(4, 32'hCAFE_0000);
    b = 0;
    while (!wb_cyc_o && b < 20) begin
      @(negedge clk);
      b++;
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({wb_cyc_o, wb_stb_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o} !== '0) begin
        miscompares++;
        $display("[TB] FAIL reset_mid: got cyc=%b stb=%b addr=%h dat=%h sel=%h cti=%b expected all 0",
                 wb_cyc_o, wb_stb_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o);
      end
    end
    rst = 1'b0;
    beat_q.delete();
    rdat_q.delete();
    done_q.delete();
    repeat (4) @(negedge clk);
    vectors++;
    if ({wb_cyc_o, cmd_ready, done_count} !== {1'b0, 1'b1, start}) begin
      miscompares++;
      $display("[TB] FAIL reset_recover: got cyc=%b ready=%b dones=%0d expected cyc=0 ready=1 dones=%0d",
               wb_cyc_o, cmd_ready, done_count, start);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_burst();
    test_wrap();
    test_back_to_back();
    test_stray_ack();
`ifdef WB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got simulation still running at 500000 expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
